// File: rtl/larpix_rx_pkg.sv
// Shared types for the PISO UART packet receiver.
package larpix_rx_pkg;

  localparam int unsigned WIDTH_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;

  typedef logic [WIDTH_DEFAULT-1:0] packet_t;

endpackage

// File: rtl/rx_packet_fifo.sv
// Synchronous packet FIFO; pointers carry one extra wrap bit to separate full from empty.
module rx_packet_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr;
  logic             do_rd;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_rd    = rd_en && !empty;
    // a pop in the same cycle frees the slot, so a full FIFO may still accept
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/piso_packet_rx.sv
// UART-style serial packet receiver feeding a packet FIFO.
// Optional odd-parity drop enabled by defining PIXEL_RX_PARITY_CHECK_EN.
module piso_packet_rx
  import larpix_rx_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEFAULT,
  parameter int unsigned CLK_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             piso,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overflow,
  output logic [7:0]       drop_count
);

  localparam int unsigned CYC_W = $clog2(CLK_PER_BIT);
  localparam int unsigned BIT_W = $clog2(WIDTH);
  localparam int unsigned HALF  = CLK_PER_BIT / 2;

  logic             sync1_q, sync2_q;
  rx_state_t        state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] pkt_q, pkt_d;
  logic             push_q, push_d;
  logic             frame_err_q, frame_err_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_q, drop_d;
  logic             parity_drop;
  logic             parity_bad;
  logic [1:0]       drop_inc;
  logic [8:0]       drop_sum;
  logic             rx_bit;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  assign rx_bit = sync2_q;

`ifdef PIXEL_RX_PARITY_CHECK_EN
  logic parity_err_q;
  assign parity_bad = ~^shift_q;
  assign parity_err = parity_err_q;
`else
  assign parity_bad = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    pkt_d       = pkt_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    parity_drop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cyc_d = '0;
        bit_d = '0;
        if (!rx_bit) state_d = ST_START;
      end
      ST_START: begin
        if (cyc_q == CYC_W'(HALF - 1)) begin
          cyc_d   = '0;
          state_d = rx_bit ? ST_IDLE : ST_DATA;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cyc_q == CYC_W'(CLK_PER_BIT - 1)) begin
          cyc_d   = '0;
          shift_d = {rx_bit, shift_q[WIDTH-1:1]};
          if (bit_q == BIT_W'(WIDTH - 1)) state_d = ST_STOP;
          else                            bit_d   = bit_q + 1'b1;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cyc_q == CYC_W'(CLK_PER_BIT - 1)) begin
          cyc_d   = '0;
          state_d = ST_IDLE;
          if (!rx_bit)         frame_err_d = 1'b1;
          else if (parity_bad) parity_drop = 1'b1;
          else begin
            push_d = 1'b1;
            pkt_d  = shift_q;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rx_valid = !fifo_empty;
  assign pop      = rx_valid && rx_ready;

  always_comb begin
    overflow_d = push_q && fifo_full && !pop;
    drop_inc   = {1'b0, overflow_d} + {1'b0, parity_drop};
    drop_sum   = {1'b0, drop_q} + {7'd0, drop_inc};
    drop_d     = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      pkt_q       <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
    end else begin
      sync1_q     <= piso;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      pkt_q       <= pkt_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
    end
  end

`ifdef PIXEL_RX_PARITY_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_err_q <= 1'b0;
    else       parity_err_q <= parity_drop;
  end
`endif

  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

  rx_packet_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_q),
    .wr_data (pkt_q),
    .rd_en   (rx_ready),
    .rd_data (rx_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_piso_packet_rx.sv
// Self-checking bench for piso_packet_rx: vector table, corner sequences, random traffic.
module tb_piso_packet_rx;
  import larpix_rx_pkg::*;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             piso;
  logic             rx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             frame_err;
  logic             parity_err;
  logic             overflow;
  logic [7:0]       drop_count;

  always #5 clk = ~clk;

  piso_packet_rx #(
    .WIDTH       (WIDTH),
    .CLK_PER_BIT (CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .piso       (piso),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  int      checks = 0;
  int      errors = 0;
  packet_t got_q[$];
  packet_t exp_q[$];
  int      n_frame = 0, n_parity = 0, n_ovf = 0, n_valid = 0;
  logic    hold = 1'b0;
  packet_t hold_data;
  bit      rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Packet dropped for parity when its bits hold an even number of ones.
  function automatic bit parity_drop_model(input packet_t d);
`ifdef PIXEL_RX_PARITY_CHECK_EN
    return ($countones(d) % 2) == 0;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      hold = 1'b0;
    end else begin
      if (hold && rx_valid) check("hold_stable", rx_data, hold_data);
      if (rx_valid) n_valid++;
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) n_frame++;
      if (parity_err) n_parity++;
      if (overflow) n_ovf++;
      hold      = rx_valid && !rx_ready;
      hold_data = rx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_bit(input logic b);
    piso = b;
    repeat (CPB) tick();
  endtask

  task automatic send_packet(input packet_t d, input logic stop, input int unsigned gap);
    send_bit(1'b0);
    for (int i = 0; i < int'(WIDTH); i++) send_bit(d[i]);
    send_bit(stop);
    for (int unsigned g = 0; g < gap; g++) send_bit(1'b1);
  endtask

  typedef struct {
    packet_t data;
    logic    stop;
    bit      exp_deliver;
    bit      exp_frame;
    bit      exp_parity;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int b_frame, b_par, b_valid, b_ovf;
    int e_frame, e_par;
    logic [7:0] b_drop;

    vecs[0].data = 64'h8000_0000_0000_0001; vecs[0].stop = 1'b1;
    vecs[1].data = 64'h0000_0000_0000_0003; vecs[1].stop = 1'b1;
    vecs[2].data = 64'h0123_4567_89AB_CDEF; vecs[2].stop = 1'b1;
    vecs[3].data = 64'hFFFF_FFFF_FFFF_FFFF; vecs[3].stop = 1'b1;
    vecs[4].data = 64'h0000_0000_0000_0001; vecs[4].stop = 1'b0;
    vecs[5].data = 64'h8000_0000_0000_0000; vecs[5].stop = 1'b1;
    vecs[6].data = 64'hA5A5_A5A5_A5A5_A5A5; vecs[6].stop = 1'b0;
    foreach (vecs[i]) begin
      vecs[i].exp_frame   = !vecs[i].stop;
      vecs[i].exp_parity  = vecs[i].stop && parity_drop_model(vecs[i].data);
      vecs[i].exp_deliver = vecs[i].stop && !vecs[i].exp_parity;
    end

    reset    = 1'b1;
    piso     = 1'b1;
    rx_ready = 1'b1;
    repeat (3) tick();
    check("reset_rx_valid",   64'(rx_valid),   64'd0);
    check("reset_rx_data",    rx_data,         64'd0);
    check("reset_frame_err",  64'(frame_err),  64'd0);
    check("reset_parity_err", 64'(parity_err), 64'd0);
    check("reset_overflow",   64'(overflow),   64'd0);
    check("reset_drop_count", 64'(drop_count), 64'd0);
    reset = 1'b0;
    repeat (4) tick();

    // Table-driven single packets with a consumer always ready
    foreach (vecs[i]) begin
      got_q.delete();
      b_frame = n_frame; b_par = n_parity; b_valid = n_valid; b_drop = drop_count;
      send_packet(vecs[i].data, vecs[i].stop, 4);
      repeat (4) tick();
      check($sformatf("vec%0d_count", i), 64'(got_q.size()), 64'(vecs[i].exp_deliver));
      if (vecs[i].exp_deliver && got_q.size() > 0)
        check($sformatf("vec%0d_data", i), got_q[0], vecs[i].data);
      check($sformatf("vec%0d_valid_cycles", i), 64'(n_valid - b_valid), 64'(vecs[i].exp_deliver));
      check($sformatf("vec%0d_frame", i), 64'(n_frame - b_frame), 64'(vecs[i].exp_frame));
      check($sformatf("vec%0d_parity", i), 64'(n_parity - b_par), 64'(vecs[i].exp_parity));
      check($sformatf("vec%0d_drop", i), 64'(8'(drop_count - b_drop)), 64'(vecs[i].exp_parity));
    end

    // Overflow: six packets into a four-deep FIFO with the consumer stalled
    got_q.delete();
    rx_ready = 1'b0;
    b_ovf = n_ovf; b_drop = drop_count;
    for (int i = 0; i < 6; i++) send_packet(64'h1 << i, 1'b1, 2);
    repeat (4) tick();
    check("ovf_pulses", 64'(n_ovf - b_ovf), 64'd2);
    check("ovf_drop_count", 64'(8'(drop_count - b_drop)), 64'd2);
    check("ovf_valid_held", 64'(rx_valid), 64'd1);
    check("ovf_head_data", rx_data, 64'h1);
    rx_ready = 1'b1;
    repeat (8) tick();
    check("ovf_drained", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) check($sformatf("ovf_order%0d", i), got_q[i], 64'h1 << i);

    // Short low glitch while idle must not start a packet
    got_q.delete();
    b_frame = n_frame; b_par = n_parity; b_valid = n_valid; b_ovf = n_ovf; b_drop = drop_count;
    piso = 1'b0;
    repeat (2) tick();
    piso = 1'b1;
    repeat (40) tick();
    check("glitch_no_valid", 64'(n_valid - b_valid), 64'd0);
    check("glitch_no_pulse", 64'((n_frame - b_frame) + (n_parity - b_par) + (n_ovf - b_ovf)), 64'd0);
    check("glitch_drop", 64'(drop_count), 64'(b_drop));
    send_packet(64'h0000_0000_0000_0007, 1'b1, 3);
    repeat (4) tick();
    check("glitch_after_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) check("glitch_after_data", got_q[0], 64'h7);

    // Reset after 20 data bits discards the partial packet
    got_q.delete();
    send_bit(1'b0);
    for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)));
    reset = 1'b1;
    piso  = 1'b1;
    repeat (3) tick();
    check("midreset_valid", 64'(rx_valid), 64'd0);
    check("midreset_drop", 64'(drop_count), 64'd0);
    reset = 1'b0;
    repeat (8) tick();
    send_packet(64'h0000_0000_0000_0007, 1'b1, 3);
    repeat (4) tick();
    check("midreset_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) check("midreset_data", got_q[0], 64'h7);

    // Random traffic, some back-to-back, random consumer backpressure
    got_q.delete();
    exp_q.delete();
    e_frame = 0; e_par = 0;
    b_frame = n_frame; b_par = n_parity; b_drop = drop_count;
    rand_ready = 1'b1;
    for (int n = 0; n < 25; n++) begin
      packet_t     d;
      logic        stop;
      int unsigned gap;
      d    = {$urandom, $urandom};
      stop = ($urandom_range(0, 9) != 0);
      gap  = stop ? $urandom_range(0, 2) : 2;
      if (!stop) e_frame++;
      else if (parity_drop_model(d)) e_par++;
      else exp_q.push_back(d);
      send_packet(d, stop, gap);
    end
    rand_ready = 1'b0;
    rx_ready   = 1'b1;
    repeat (12) tick();
    check("rand_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("rand_data%0d", i), got_q[i], exp_q[i]);
    check("rand_frame", 64'(n_frame - b_frame), 64'(e_frame));
    check("rand_parity", 64'(n_parity - b_par), 64'(e_par));
    check("rand_drop", 64'(8'(drop_count - b_drop)), 64'(e_par));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
